// File: rtl/rv32_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALUOp / ALUControl codes and datapath mux select encodings.
package rv32_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE: imm_src_of = IMM_S;
      OP_BEQ:   imm_src_of = IMM_B;
      OP_JAL:   imm_src_of = IMM_J;
      default:  imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. Optional mem_ready exists only when
// MC_MEM_READY_EN is defined.
interface multicycle_controller_if #(parameter int ALU_CTRL_W = 3) ();
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7_5;
  logic                  Zero;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  IRWrite;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic                  RegWrite;
  logic                  IllegalInstr;
`ifdef MC_MEM_READY_EN
  // Memory handshake: the controller holds an access state with its outputs
  // stable; the access completes in the cycle where mem_ready is sampled 1.
  logic                  mem_ready;

  modport master (
    input  opcode, funct3, funct7_5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, IllegalInstr
  );
  modport slave (
    output opcode, funct3, funct7_5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, IllegalInstr
  );
`else
  modport master (
    input  opcode, funct3, funct7_5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, IllegalInstr
  );
  modport slave (
    output opcode, funct3, funct7_5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, IllegalInstr
  );
`endif
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALUOp/funct -> ALUControl decode.
module mc_alu_decoder
  import rv32_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  aluop_t                alu_op,
  input  logic [2:0]            funct3,
  input  logic                  op5,
  input  logic                  funct7_5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_CTRL_W'(ALUC_ADD);
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_CTRL_W'(ALUC_ADD);
      ALUOP_SUB: alu_control = ALU_CTRL_W'(ALUC_SUB);
      ALUOP_FUNCT: begin
        case (funct3)
          // I-type immediates may carry bit 30 set, so sub needs op5 too
          3'b000:  alu_control = (op5 & funct7_5) ? ALU_CTRL_W'(ALUC_SUB)
                                                  : ALU_CTRL_W'(ALUC_ADD);
          3'b010:  alu_control = ALU_CTRL_W'(ALUC_SLT);
          3'b110:  alu_control = ALU_CTRL_W'(ALUC_OR);
          3'b111:  alu_control = ALU_CTRL_W'(ALUC_AND);
          default: alu_control = ALU_CTRL_W'(ALUC_ADD);
        endcase
      end
      default: alu_control = ALU_CTRL_W'(ALUC_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM. Define MC_MEM_READY_EN to add memory
// wait states in FETCH/MEMREAD/MEMWRITE.
module multicycle_controller
  import rv32_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus,
  output state_t                  state_dbg
);

  state_t state, next_state;
  aluop_t alu_op;
  logic   mem_rdy;
  logic   pc_update, branch, ir_write, mem_write, reg_write, illegal;

`ifdef MC_MEM_READY_EN
  assign mem_rdy = bus.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RD2;
    case (state)
      S_FETCH: begin
        ir_write      = mem_rdy;
        pc_update     = mem_rdy;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURES;
        next_state    = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECUTER;
          OP_I:              next_state = S_EXECUTEI;
          OP_JAL:            next_state = S_JAL;
          OP_BEQ:            next_state = S_BEQ;
          default: begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        next_state  = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = RES_ALUOUT;
        next_state    = mem_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_write     = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = RES_ALUOUT;
        mem_write     = 1'b1;
        next_state    = mem_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_RD2;
        alu_op      = ALUOP_FUNCT;
        next_state  = S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        reg_write     = 1'b1;
        next_state    = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA   = SRCA_OLDPC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALUOUT;
        pc_update     = 1'b1;
        next_state    = S_ALUWB;
      end
      S_BEQ: begin
        bus.ALUSrcA   = SRCA_RD1;
        bus.ALUSrcB   = SRCB_RD2;
        bus.ResultSrc = RES_ALUOUT;
        alu_op        = ALUOP_SUB;
        branch        = 1'b1;
        next_state    = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Reset suppresses every architectural write regardless of state
  assign bus.PCWrite      = ~reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite      = ~reset & ir_write;
  assign bus.MemWrite     = ~reset & mem_write;
  assign bus.RegWrite     = ~reset & reg_write;
  assign bus.IllegalInstr = ~reset & illegal;
  assign bus.ImmSrc       = imm_src_of(bus.opcode);
  assign state_dbg        = state;

  mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.opcode[5]),
    .funct7_5    (bus.funct7_5),
    .alu_control (bus.ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction streams,
// per-cycle expected output vectors checked by a negedge monitor.
module tb_multicycle_controller;
  import rv32_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] aluc;
    logic       rw, ill;
  } obs_t;

  localparam int W = $bits(obs_t);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  next_ir = 32'h0;
  logic         mem_ready = 1'b1;
  state_t       state_dbg;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  multicycle_controller_if #(.ALU_CTRL_W(3)) bus ();

  multicycle_controller #(.ALU_CTRL_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

`ifdef MC_MEM_READY_EN
  assign bus.mem_ready = mem_ready;
`endif

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_alu(input int op_sel, input logic [6:0] op,
                                         input logic [2:0] f3, input logic f7);
    if (op_sel == 0) return 3'b000;
    if (op_sel == 1) return 3'b001;
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle, with a mask of the fields that matter there
  task automatic model(input state_t s, input logic [31:0] ir, input logic z,
                       input logic rdy, input logic rst,
                       output obs_t v, output obs_t m);
    logic [6:0] op;
    op = ir[6:0];
    v = '0;
    m = '0;
    m.pcw = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.ill = 1'b1;
    if (rst) return;
    m.st = 4'hF;
    m.imm = 2'b11;
    v.st = s;
    case (op)
      7'b0100011: v.imm = 2'b01;
      7'b1100011: v.imm = 2'b10;
      7'b1101111: v.imm = 2'b11;
      default:    v.imm = 2'b00;
    endcase
    case (s)
      S_FETCH: begin
        v.irw = rdy; v.pcw = rdy; v.adr = 1'b0; m.adr = 1'b1;
        v.sa = 2'b00; v.sb = 2'b10; v.rs = 2'b10; v.aluc = 3'b000;
        m.sa = 2'b11; m.sb = 2'b11; m.rs = 2'b11; m.aluc = 3'b111;
      end
      S_DECODE: begin
        v.sa = 2'b01; v.sb = 2'b01; v.aluc = 3'b000;
        m.sa = 2'b11; m.sb = 2'b11; m.aluc = 3'b111;
        v.ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1101111, 7'b1100011});
      end
      S_MEMADR: begin
        v.sa = 2'b10; v.sb = 2'b01; v.aluc = 3'b000;
        m.sa = 2'b11; m.sb = 2'b11; m.aluc = 3'b111;
      end
      S_MEMREAD: begin
        v.rs = 2'b00; v.adr = 1'b1; m.rs = 2'b11; m.adr = 1'b1;
      end
      S_MEMWB: begin
        v.rs = 2'b01; v.rw = 1'b1; m.rs = 2'b11;
      end
      S_MEMWRITE: begin
        v.rs = 2'b00; v.adr = 1'b1; v.mw = 1'b1; m.rs = 2'b11; m.adr = 1'b1;
      end
      S_EXECUTER, S_EXECUTEI: begin
        v.sa = 2'b10; v.sb = (s == S_EXECUTER) ? 2'b00 : 2'b01;
        v.aluc = exp_alu(2, op, ir[14:12], ir[30]);
        m.sa = 2'b11; m.sb = 2'b11; m.aluc = 3'b111;
      end
      S_ALUWB: begin
        v.rs = 2'b00; v.rw = 1'b1; m.rs = 2'b11;
      end
      S_JAL: begin
        v.sa = 2'b01; v.sb = 2'b10; v.aluc = 3'b000; v.rs = 2'b00; v.pcw = 1'b1;
        m.sa = 2'b11; m.sb = 2'b11; m.aluc = 3'b111; m.rs = 2'b11;
      end
      S_BEQ: begin
        v.sa = 2'b10; v.sb = 2'b00; v.aluc = 3'b001; v.rs = 2'b00; v.pcw = z;
        m.sa = 2'b11; m.sb = 2'b11; m.aluc = 3'b111; m.rs = 2'b11;
      end
      default: ;
    endcase
  endtask

  // Drive one cycle's inputs just after the edge and queue its expected outputs
  task automatic step(input state_t s, input logic z = 1'b0,
                      input logic rdy = 1'b1, input logic rst = 1'b0);
    obs_t v, m;
    @(posedge clk);
    #1;
    reset        = rst;
    bus.Zero     = z;
    mem_ready    = rdy;
    bus.opcode   = next_ir[6:0];
    bus.funct3   = next_ir[14:12];
    bus.funct7_5 = next_ir[30];
    model(s, next_ir, z, rdy, rst, v, m);
    exp_q.push_back(v);
    mask_q.push_back(m);
  endtask

  always @(negedge clk) begin
    obs_t act;
    logic [W-1:0] e, mk;
    cyc++;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      mk = mask_q.pop_front();
      act = '{st: state_dbg, pcw: bus.PCWrite, adr: bus.AdrSrc, mw: bus.MemWrite,
              irw: bus.IRWrite, rs: bus.ResultSrc, sa: bus.ALUSrcA,
              sb: bus.ALUSrcB, imm: bus.ImmSrc, aluc: bus.ALUControl,
              rw: bus.RegWrite, ill: bus.IllegalInstr};
      checks++;
      if (((act ^ e) & mk) != '0) begin
        errors++;
        $display("FAIL outputs cycle=%0d ir=%h: got %h expected %h (mask %h)",
                 cyc, bus.opcode, act, e, mk);
      end
    end
  end

  initial begin
    bus.Zero = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0;

    // reset held two cycles, then add x3,x1,x2
    next_ir = 32'h002081B3;
    step(S_FETCH, 0, 1, 1); step(S_FETCH, 0, 1, 1);
    step(S_FETCH); step(S_DECODE); step(S_EXECUTER); step(S_ALUWB);
    // sub x3,x1,x2
    next_ir = 32'h402081B3;
    step(S_FETCH); step(S_DECODE); step(S_EXECUTER); step(S_ALUWB);
    // addi x3,x1,-1024: bit 30 set but I-type stays add
    next_ir = 32'hC0008193;
    step(S_FETCH); step(S_DECODE); step(S_EXECUTEI); step(S_ALUWB);
    // ori x3,x1,6
    next_ir = 32'h0060E193;
    step(S_FETCH); step(S_DECODE); step(S_EXECUTEI); step(S_ALUWB);
    // lw x5,4(x0)
    next_ir = 32'h00402283;
    step(S_FETCH); step(S_DECODE); step(S_MEMADR); step(S_MEMREAD); step(S_MEMWB);
    // sw x5,8(x0)
    next_ir = 32'h00502423;
    step(S_FETCH); step(S_DECODE); step(S_MEMADR); step(S_MEMWRITE);
    // beq taken, then not taken
    next_ir = 32'h00208463;
    step(S_FETCH, 1); step(S_DECODE, 1); step(S_BEQ, 1);
    step(S_FETCH, 0); step(S_DECODE, 0); step(S_BEQ, 0);
    // jal x1,16
    next_ir = 32'h010000EF;
    step(S_FETCH); step(S_DECODE); step(S_JAL); step(S_ALUWB);
    // illegal opcode 0x7F
    next_ir = 32'h0000007F;
    step(S_FETCH); step(S_DECODE);
    // lw abandoned by reset in MEMREAD, then slt x3,x1,x2 completes
    next_ir = 32'h00402283;
    step(S_FETCH); step(S_DECODE); step(S_MEMADR); step(S_MEMREAD, 0, 1, 1);
    next_ir = 32'h0020A1B3;
    step(S_FETCH); step(S_DECODE); step(S_EXECUTER); step(S_ALUWB);
    // and x3,x1,x2
    next_ir = 32'h0020F1B3;
    step(S_FETCH); step(S_DECODE); step(S_EXECUTER); step(S_ALUWB);
`ifdef MC_MEM_READY_EN
    // lw with three wait cycles in FETCH and in MEMREAD: 11 cycles
    next_ir = 32'h00402283;
    step(S_FETCH, 0, 0); step(S_FETCH, 0, 0); step(S_FETCH, 0, 0);
    step(S_FETCH, 0, 1); step(S_DECODE); step(S_MEMADR);
    step(S_MEMREAD, 0, 0); step(S_MEMREAD, 0, 0); step(S_MEMREAD, 0, 0);
    step(S_MEMREAD, 0, 1); step(S_MEMWB);
    // sw waiting two cycles in MEMWRITE, MemWrite held
    next_ir = 32'h00502423;
    step(S_FETCH); step(S_DECODE); step(S_MEMADR);
    step(S_MEMWRITE, 0, 0); step(S_MEMWRITE, 0, 0); step(S_MEMWRITE, 0, 1);
    // reset overrides a FETCH wait
    next_ir = 32'h002081B3;
    step(S_FETCH, 0, 0); step(S_FETCH, 0, 0, 1);
    step(S_FETCH, 0, 1); step(S_DECODE); step(S_EXECUTER); step(S_ALUWB);
`endif
    next_ir = 32'h002081B3;
    step(S_FETCH);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
